// File: rtl/rr_mux_arbiter_if.sv
// Request/data/grant bundle between four sources and the round-robin mux arbiter.
// master = sources and output consumer, slave = arbiter.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]            req;
  logic [3:0][WIDTH-1:0] data;
  logic [3:0]            gnt;
  logic [1:0]            sel;
  logic [WIDTH-1:0]      y;
  logic                  y_valid;

  modport master (output req, data, input gnt, sel, y, y_valid);
  modport slave  (input req, data, output gnt, sel, y, y_valid);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter steering the granted source onto a registered output,
// with each grant capped at MAX_HOLD words while another source is waiting.
module rr_mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);

  state_t           r_state, w_state;
  logic [1:0]       r_ptr, w_ptr;
  logic [1:0]       r_sel, w_sel;
  logic [3:0]       r_gnt, w_gnt;
  logic [3:0]       r_hold, w_hold;
  logic [WIDTH-1:0] r_y, w_y;
  logic             r_y_valid, w_y_valid;
  logic             r_skip, w_skip;
  logic [3:0]       w_others;
  logic [1:0]       w_win_any, w_win_oth;

  // First set bit searching upward from p+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_others  = bus.req & ~r_gnt;
  assign w_win_any = rr_pick(bus.req, r_ptr);
  assign w_win_oth = rr_pick(w_others, r_ptr);

  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_sel     = r_sel;
    w_gnt     = r_gnt;
    w_hold    = r_hold;
    w_y       = r_y;
    w_y_valid = 1'b0;
    w_skip    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state = S_GRANT;
          w_gnt   = 4'b0001 << w_win_any;
          w_sel   = w_win_any;
          w_ptr   = w_win_any;
          w_hold  = 4'd0;
        end
      end
      S_GRANT: begin
        if (bus.req[r_sel] && !r_skip) begin
          w_y       = bus.data[r_sel];
          w_y_valid = 1'b1;
          if (r_hold != HOLD_MAX) w_hold = r_hold + 4'd1;
          // A saturated holder is still cut off as soon as someone else asks.
          if (r_hold >= HOLD_LAST && |w_others) begin
            w_gnt  = 4'b0001 << w_win_oth;
            w_sel  = w_win_oth;
            w_ptr  = w_win_oth;
            w_hold = 4'd0;
            w_skip = 1'b1;
          end
        end else if (!bus.req[r_sel]) begin
          if (|w_others) begin
            w_gnt  = 4'b0001 << w_win_oth;
            w_sel  = w_win_oth;
            w_ptr  = w_win_oth;
            w_hold = 4'd0;
          end else begin
            w_state = S_IDLE;
            w_gnt   = 4'b0000;
          end
        end
        // r_skip with req held: the preempted-in source's settle cycle, no capture.
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd3;
      r_sel     <= 2'd0;
      r_gnt     <= 4'b0000;
      r_hold    <= 4'd0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_sel     <= w_sel;
      r_gnt     <= w_gnt;
      r_hold    <= w_hold;
      r_y       <= w_y;
      r_y_valid <= w_y_valid;
      r_skip    <= w_skip;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.y       = r_y;
  assign bus.y_valid = r_y_valid;

endmodule
